// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Producer-side companion to the stage-3 operand forwarding logic. It tracks
// destination registers whose results cannot be forwarded yet:
//   - a load that is still in flight, and
//   - an outstanding multi-cycle MUL/DIV result.
// While such a result is pending, a dependent instruction in decode is held
// (STALL freezes PC and IF/ID) and a bubble is pushed into ID/EX (BUBBLE).
//
// Ports:
//   CLK               pipeline clock, rising edge
//   RESET             synchronous, active-high reset
//   ISSUE_VALID       decode presents a valid instruction this cycle
//   ISSUE_RS1/RS2     source register addresses
//   ISSUE_USES_RS1/2  instruction actually reads RS1/RS2
//   ISSUE_RD          destination register address
//   ISSUE_REGWRITE_EN instruction writes RD
//   ISSUE_IS_LOAD     instruction is a load
//   ISSUE_IS_MULDIV   instruction is a multi-cycle MUL/DIV
//   MULDIV_DONE       one-cycle pulse: MUL/DIV result valid this cycle
//   STALL             hold PC and IF/ID
//   BUBBLE            force NOP into ID/EX (same as STALL)
//   MULDIV_BUSY       MUL/DIV tracker is waiting for a result
//   STALL_COUNT       saturating count of stall cycles
//
// Optional feature macro: HAZARD_SCOREBOARD_STATS_EN
//   defined   -> STALL_COUNT is a saturating stall-cycle counter
//   undefined -> no counter is built, STALL_COUNT reads 0
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int STAT_W   = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ISSUE_VALID,
    input  logic [ADDR_W-1:0] ISSUE_RS1,
    input  logic [ADDR_W-1:0] ISSUE_RS2,
    input  logic              ISSUE_USES_RS1,
    input  logic              ISSUE_USES_RS2,
    input  logic [ADDR_W-1:0] ISSUE_RD,
    input  logic              ISSUE_REGWRITE_EN,
    input  logic              ISSUE_IS_LOAD,
    input  logic              ISSUE_IS_MULDIV,
    input  logic              MULDIV_DONE,
    output logic              STALL,
    output logic              BUBBLE,
    output logic              MULDIV_BUSY,
    output logic [STAT_W-1:0] STALL_COUNT
);

    // Load latency is at most 3, so a 2-bit down-counter is enough.
    localparam int CNT_W = 2;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Load-pending table
    logic [LOAD_LAT-1:0] ld_valid;
    logic [ADDR_W-1:0]   ld_rd  [LOAD_LAT];
    logic [CNT_W-1:0]    ld_cnt [LOAD_LAT];
    logic [LOAD_LAT-1:0] alloc_sel;
    logic                alloc_req;
    logic                load_hit;

    // MUL/DIV tracker
    md_state_t         md_state;
    md_state_t         md_state_next;
    logic [ADDR_W-1:0] md_rd;
    logic [ADDR_W-1:0] md_rd_next;
    logic [ADDR_W-1:0] md_dest;
    logic              md_pending;
    logic              md_hit;
    logic              struct_hit;

    logic stall_int;
    logic accept;

    // Compare the issuing sources against every live load entry. Entries are
    // never allocated for x0, so a source of x0 can never hit here.
    always_comb begin
        load_hit = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (ld_valid[i]) begin
                if (ISSUE_USES_RS1 && (ISSUE_RS1 == ld_rd[i])) load_hit = 1'b1;
                if (ISSUE_USES_RS2 && (ISSUE_RS2 == ld_rd[i])) load_hit = 1'b1;
            end
        end
    end

    // A MUL/DIV result arriving this very cycle is picked up by the stage-4
    // forward path, so the same-cycle DONE pulse lifts both the data and the
    // structural hazard. A latched rd of 0 means "no destination".
    always_comb begin
        md_pending = (md_state == MD_BUSY) && !MULDIV_DONE;
        md_hit     = 1'b0;
        if (md_pending && (md_rd != '0)) begin
            if (ISSUE_USES_RS1 && (ISSUE_RS1 == md_rd))   md_hit = 1'b1;
            if (ISSUE_USES_RS2 && (ISSUE_RS2 == md_rd))   md_hit = 1'b1;
            if (ISSUE_REGWRITE_EN && (ISSUE_RD == md_rd)) md_hit = 1'b1;
        end
        struct_hit = md_pending && ISSUE_IS_MULDIV;
    end

    // Reset masks the stall so a reset cycle never counts or holds the pipe.
    assign stall_int = ISSUE_VALID && !RESET && (load_hit || md_hit || struct_hit);
    assign accept    = ISSUE_VALID && !stall_int;
    assign STALL     = stall_int;
    assign BUBBLE    = stall_int;

    assign alloc_req = accept && ISSUE_IS_LOAD && ISSUE_REGWRITE_EN && (ISSUE_RD != '0);

    // Pick the lowest free slot. A slot whose counter is 1 expires on this
    // edge and can be reused, so LOAD_LAT slots always suffice for one load
    // per cycle.
    always_comb begin
        logic taken;
        alloc_sel = '0;
        taken     = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (!taken && (!ld_valid[i] || (ld_cnt[i] == CNT_W'(1)))) begin
                alloc_sel[i] = 1'b1;
                taken        = 1'b1;
            end
        end
    end

    // Load table update: allocate, or count down and retire at zero.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ld_valid <= '0;
            for (int i = 0; i < LOAD_LAT; i++) begin
                ld_rd[i]  <= '0;
                ld_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                if (alloc_req && alloc_sel[i]) begin
                    ld_valid[i] <= 1'b1;
                    ld_rd[i]    <= ISSUE_RD;
                    ld_cnt[i]   <= CNT_W'(LOAD_LAT);
                end else if (ld_valid[i]) begin
                    ld_cnt[i] <= ld_cnt[i] - CNT_W'(1);
                    if (ld_cnt[i] == CNT_W'(1)) begin
                        ld_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // An instruction that does not write back leaves nothing to wait on.
    assign md_dest = ISSUE_REGWRITE_EN ? ISSUE_RD : '0;

    // MUL/DIV tracker state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            md_state <= MD_IDLE;
            md_rd    <= '0;
        end else begin
            md_state <= md_state_next;
            md_rd    <= md_rd_next;
        end
    end

    // MUL/DIV next state. In BUSY, a new MUL/DIV can only be accepted in the
    // DONE cycle (otherwise the structural stall blocks it); the tracker then
    // stays BUSY and follows the new destination.
    always_comb begin
        md_state_next = md_state;
        md_rd_next    = md_rd;
        MULDIV_BUSY   = 1'b0;
        case (md_state)
            MD_IDLE: begin
                if (accept && ISSUE_IS_MULDIV) begin
                    md_state_next = MD_BUSY;
                    md_rd_next    = md_dest;
                end
            end
            MD_BUSY: begin
                MULDIV_BUSY = 1'b1;
                if (accept && ISSUE_IS_MULDIV) begin
                    md_state_next = MD_BUSY;
                    md_rd_next    = md_dest;
                end else if (MULDIV_DONE) begin
                    md_state_next = MD_IDLE;
                end
            end
            default: begin
                md_state_next = MD_IDLE;
            end
        endcase
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt;

    // Saturating stall-cycle counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
        end else if (stall_int && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STAT_W'(1);
        end
    end

    assign STALL_COUNT = stall_cnt;
`else
    assign STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

    localparam int ADDR_W = 5;
    localparam int STAT_W = 16;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RESET;
    logic              ISSUE_VALID;
    logic [ADDR_W-1:0] ISSUE_RS1;
    logic [ADDR_W-1:0] ISSUE_RS2;
    logic              ISSUE_USES_RS1;
    logic              ISSUE_USES_RS2;
    logic [ADDR_W-1:0] ISSUE_RD;
    logic              ISSUE_REGWRITE_EN;
    logic              ISSUE_IS_LOAD;
    logic              ISSUE_IS_MULDIV;
    logic              MULDIV_DONE;
    logic              STALL;
    logic              BUBBLE;
    logic              MULDIV_BUSY;
    logic [STAT_W-1:0] STALL_COUNT;

    int checkCount = 0;
    int errorCount = 0;

    hazard_scoreboard #(
        .ADDR_W  (ADDR_W),
        .LOAD_LAT(1),
        .STAT_W  (STAT_W)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .ISSUE_VALID      (ISSUE_VALID),
        .ISSUE_RS1        (ISSUE_RS1),
        .ISSUE_RS2        (ISSUE_RS2),
        .ISSUE_USES_RS1   (ISSUE_USES_RS1),
        .ISSUE_USES_RS2   (ISSUE_USES_RS2),
        .ISSUE_RD         (ISSUE_RD),
        .ISSUE_REGWRITE_EN(ISSUE_REGWRITE_EN),
        .ISSUE_IS_LOAD    (ISSUE_IS_LOAD),
        .ISSUE_IS_MULDIV  (ISSUE_IS_MULDIV),
        .MULDIV_DONE      (MULDIV_DONE),
        .STALL            (STALL),
        .BUBBLE           (BUBBLE),
        .MULDIV_BUSY      (MULDIV_BUSY),
        .STALL_COUNT      (STALL_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one decode slot; called 1 time unit after a rising edge.
    task automatic applyStimulus(input logic valid,
                                 input logic [ADDR_W-1:0] rs1, input logic u1,
                                 input logic [ADDR_W-1:0] rs2, input logic u2,
                                 input logic [ADDR_W-1:0] rd, input logic we,
                                 input logic ld, input logic md, input logic done);
        ISSUE_VALID       = valid;
        ISSUE_RS1         = rs1;
        ISSUE_USES_RS1    = u1;
        ISSUE_RS2         = rs2;
        ISSUE_USES_RS2    = u2;
        ISSUE_RD          = rd;
        ISSUE_REGWRITE_EN = we;
        ISSUE_IS_LOAD     = ld;
        ISSUE_IS_MULDIV   = md;
        MULDIV_DONE       = done;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkStall(input string tag, input logic expected);
        checkOutput({tag, "_stall"}, {31'b0, STALL}, {31'b0, expected});
        checkOutput({tag, "_bubble"}, {31'b0, BUBBLE}, {31'b0, expected});
    endtask

    function automatic logic [31:0] expCount(input int n);
        return STATS_ON ? n : 0;
    endfunction

    initial begin
        RESET = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        checkStall("reset", 0);
        checkOutput("reset_busy", {31'b0, MULDIV_BUSY}, 0);
        checkOutput("reset_count", {16'b0, STALL_COUNT}, 0);
        RESET = 1'b0;
        nextCycle();

        // lw x5 then add x6,x5,x1: exactly one stall cycle
        applyStimulus(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
        checkStall("lw_issue", 0);
        nextCycle();
        applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        checkStall("loaduse_c1", 1);
        nextCycle();
        applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        checkStall("loaduse_c2", 0);
        nextCycle();

        // div x7 then sub x9,x7,x3: stall 4 cycles, DONE on cycle 5
        applyStimulus(1, 1, 1, 2, 1, 7, 1, 0, 1, 0);
        checkStall("div_issue", 0);
        checkOutput("div_issue_busy", {31'b0, MULDIV_BUSY}, 0);
        nextCycle();
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1, 7, 1, 3, 1, 9, 1, 0, 0, 0);
            checkStall($sformatf("div_dep_c%0d", c), 1);
            checkOutput($sformatf("div_dep_busy_c%0d", c), {31'b0, MULDIV_BUSY}, 1);
            nextCycle();
        end
        applyStimulus(1, 7, 1, 3, 1, 9, 1, 0, 0, 1);
        checkStall("div_dep_c5", 0);
        checkOutput("div_done_busy", {31'b0, MULDIV_BUSY}, 1);
        checkOutput("count_after_div", {16'b0, STALL_COUNT}, expCount(5));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("div_idle_busy", {31'b0, MULDIV_BUSY}, 0);
        nextCycle();

        // mul x7; independent add passes; second mul stalls until DONE
        applyStimulus(1, 1, 1, 2, 1, 7, 1, 0, 1, 0);
        checkStall("mul7_issue", 0);
        nextCycle();
        applyStimulus(1, 1, 1, 2, 1, 8, 1, 0, 0, 0);
        checkStall("indep_add", 0);
        checkOutput("indep_add_busy", {31'b0, MULDIV_BUSY}, 1);
        nextCycle();
        applyStimulus(1, 1, 1, 2, 1, 10, 1, 0, 1, 0);
        checkStall("struct_c1", 1);
        nextCycle();
        applyStimulus(1, 1, 1, 2, 1, 10, 1, 0, 1, 0);
        checkStall("struct_c2", 1);
        nextCycle();
        applyStimulus(1, 1, 1, 2, 1, 10, 1, 0, 1, 1);
        checkStall("struct_done", 0);
        nextCycle();
        applyStimulus(1, 7, 1, 1, 1, 11, 1, 0, 0, 0);
        checkStall("old_rd_free", 0);
        checkOutput("chain_busy", {31'b0, MULDIV_BUSY}, 1);
        nextCycle();
        applyStimulus(1, 10, 1, 1, 1, 12, 1, 0, 0, 0);
        checkStall("new_rd_dep", 1);
        nextCycle();
        applyStimulus(1, 10, 1, 1, 1, 12, 1, 0, 0, 1);
        checkStall("new_rd_done", 0);
        checkOutput("count_after_mul", {16'b0, STALL_COUNT}, expCount(8));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mul_idle_busy", {31'b0, MULDIV_BUSY}, 0);
        nextCycle();

        // x0 is never pending
        applyStimulus(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        checkStall("lw_x0", 0);
        nextCycle();
        applyStimulus(1, 0, 1, 0, 1, 13, 1, 0, 0, 0);
        checkStall("use_x0", 0);
        nextCycle();
        applyStimulus(1, 1, 1, 2, 1, 0, 1, 0, 1, 0);
        checkStall("mul_x0", 0);
        nextCycle();
        applyStimulus(1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        checkStall("waw_x0", 0);
        checkOutput("mul_x0_busy", {31'b0, MULDIV_BUSY}, 1);
        nextCycle();
        // ISSUE_VALID low never stalls, even on a live load match
        applyStimulus(1, 1, 1, 0, 0, 14, 1, 1, 0, 0);
        checkStall("lw_x14", 0);
        nextCycle();
        applyStimulus(0, 14, 1, 0, 0, 15, 1, 0, 0, 0);
        checkStall("invalid_match", 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("x0_done_busy", {31'b0, MULDIV_BUSY}, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_idle_busy", {31'b0, MULDIV_BUSY}, 0);
        nextCycle();

        // reset while BUSY with a stalled dependent; late DONE ignored
        applyStimulus(1, 1, 1, 2, 1, 7, 1, 0, 1, 0);
        checkStall("rst_div_issue", 0);
        nextCycle();
        applyStimulus(1, 7, 1, 3, 1, 9, 1, 0, 0, 0);
        checkStall("rst_dep", 1);
        RESET = 1'b1;
        nextCycle();
        RESET = 1'b0;
        applyStimulus(1, 7, 1, 3, 1, 9, 1, 0, 0, 1);
        checkStall("post_rst", 0);
        checkOutput("post_rst_busy", {31'b0, MULDIV_BUSY}, 0);
        checkOutput("post_rst_count", {16'b0, STALL_COUNT}, 0);
        nextCycle();
        applyStimulus(1, 7, 1, 3, 1, 9, 1, 0, 0, 0);
        checkStall("late_done", 0);
        checkOutput("late_done_busy", {31'b0, MULDIV_BUSY}, 0);
        nextCycle();

        // saturation: 2^16+3 stall cycles
        applyStimulus(1, 1, 1, 2, 1, 7, 1, 0, 1, 0);
        nextCycle();
        applyStimulus(1, 7, 1, 3, 1, 9, 1, 0, 0, 0);
        repeat (65539) nextCycle();
        checkStall("sat_still", 1);
        checkOutput("sat_count", {16'b0, STALL_COUNT}, STATS_ON ? 32'hFFFF : 32'h0);
        RESET = 1'b1;
        nextCycle();
        RESET = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_clear", {16'b0, STALL_COUNT}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the stage-3 operand forwarding logic.
- Tracks destination registers whose results are not yet forwardable: a load in flight, or an outstanding multi-cycle MUL/DIV result.
- Stalls decode (stage 2) and inserts a bubble into stage 3 until each pending result reaches a forwardable stage.
- Sits beside the decode stage. Drives the PC/IF-ID hold and the ID-EX NOP-select.

Parameters:
- ADDR_W, 5, register address width.
- LOAD_LAT, 1, cycles a load destination stays pending after issue (1..3).
- STAT_W, 16, width of the optional stall counter.

Ports:
- CLK  input  1  pipeline clock, rising edge.
- RESET  input  1  synchronous, active-high.
- ISSUE_VALID  input  1  decode presents a valid instruction this cycle.
- ISSUE_RS1  input  ADDR_W  source register 1.
- ISSUE_RS2  input  ADDR_W  source register 2.
- ISSUE_USES_RS1  input  1  instruction reads RS1.
- ISSUE_USES_RS2  input  1  instruction reads RS2.
- ISSUE_RD  input  ADDR_W  destination register.
- ISSUE_REGWRITE_EN  input  1  instruction writes RD.
- ISSUE_IS_LOAD  input  1  instruction is a load.
- ISSUE_IS_MULDIV  input  1  instruction is M-extension multi-cycle.
- MULDIV_DONE  input  1  MUL/DIV unit result valid this cycle (one-cycle pulse).
- STALL  output  1  hold PC and IF/ID register.
- BUBBLE  output  1  force NOP into ID/EX.
- MULDIV_BUSY  output  1  FSM in BUSY.
- STALL_COUNT  output  STAT_W  stall-cycle count (see Optional Feature).

Behaviour:
- Reset (synchronous, CLK edge with RESET=1):
  - All load-pending entries cleared; FSM to IDLE; counter to 0.
  - STALL=0, BUBBLE=0, MULDIV_BUSY=0.
  - Reset mid-stall or mid-divide discards all pending state immediately; MULDIV_DONE in the reset cycle is ignored.
- Register x0 is never pending. Matches against x0 never stall.
- ACCEPT = ISSUE_VALID & ~STALL. State updates only on accepted issues.
- Load tracking:
  - Up to LOAD_LAT entries, each holding {valid, rd, down-counter}.
  - Accepted load with REGWRITE_EN and RD≠0 allocates an entry with counter=LOAD_LAT.
  - Each cycle every valid counter decrements; the entry invalidates when it reaches 0.
  - With LOAD_LAT=1, exactly one stall cycle per load-use pair.
- MUL/DIV FSM:
  - IDLE→BUSY on an accepted MULDIV issue; latch rd (RD=0 latched as "no dest").
  - BUSY→IDLE on MULDIV_DONE. MULDIV_DONE in IDLE is ignored.
  - BUSY with MULDIV_DONE and a new accepted MULDIV in the same cycle: stay BUSY with the new rd.
- STALL (combinational, from registered state plus issue fields) is asserted when ISSUE_VALID and any of:
  - (a) a used RS matches a valid load entry rd;
  - (b) FSM BUSY, MULDIV_DONE=0, and a used RS or RD (WAW) matches the muldiv rd;
  - (c) FSM BUSY, MULDIV_DONE=0, and ISSUE_IS_MULDIV (structural).
- MULDIV_DONE=1 in the same cycle suppresses (b)/(c); the result is taken via the stage-4 forward path.
- Load WAW needs no stall (in-order completion).
- BUBBLE = STALL. STALL=0 whenever ISSUE_VALID=0.
- Latency: state changes visible to STALL the cycle after the accepting edge.

Optional Feature:
- Macro HAZARD_SCOREBOARD_STATS_EN.
- Defined: STALL_COUNT increments on every cycle with STALL=1, saturates at all-ones, and clears on RESET.
- Undefined: no counter register is built; STALL_COUNT is tied to 0.

Test Plan:
- lw x5 accepted, next cycle add x6,x5,x1 valid → STALL=1, BUBBLE=1 for exactly 1 cycle, then accepted.
- div x7 accepted, dependent sub using x7 waits 4 cycles, MULDIV_DONE on cycle 5 → STALL high cycles 1-4, low on cycle 5 (same-cycle DONE), MULDIV_BUSY falls after that edge.
- BUSY on x7, independent add x8,x1,x2 → STALL=0. Second mul issued while BUSY → STALL=1 until DONE.
- lw x0, then add using x0 → STALL=0. mul with RD=0, then WAW check against x0 → no stall.
- RESET asserted while BUSY with a dependent instruction stalled → next cycle STALL=0, MULDIV_BUSY=0. Late MULDIV_DONE is ignored.
- With HAZARD_SCOREBOARD_STATS_EN: after the above sequences, STALL_COUNT equals the summed stall cycles (e.g. 1+4=5). Forcing 2^16+3 stall cycles reads 0xFFFF.
